data_mem_responder: RTL

//  Data-memory responder (slave) for the core's data port: serves data_rd_en_ma /

---
 rtl/data_mem_responder.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Reference data memory (slave) for the core's data port. Word-organised
//   SRAM with byte-lane writes, a programmable number of wait states and an
//   error flag for illegal, misaligned or out-of-range accesses.
//
// Ports
//   clk              in   1   clock, rising edge
//   rst_n            in   1   asynchronous reset, active low
//   clk_en           in   1   clock enable; low freezes all state and memory
//   data_addr        in   32  byte address of the access
//   data_rd_en       in   1   read request
//   data_wr_en       in   1   write request
//   data_rd_wr_ctrl  in   2   size: 00 byte, 01 half, 10 word, 11 illegal
//   data_wr          in   32  store data, right-aligned
//   data_rd          out  32  load data, right-aligned, zero-filled above
//   data_ready       out  1   one-cycle pulse: access complete
//   data_err         out  1   qualified by data_ready: access rejected
module data_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic [31:0] data_addr,
    input  logic        data_rd_en,
    input  logic        data_wr_en,
    input  logic [1:0]  data_rd_wr_ctrl,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        data_ready,
    output logic        data_err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS) * 32'd4;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } stateT;

    stateT       stateQ;
    logic [3:0]  cntQ;
    logic [31:0] addrQ;
    logic [1:0]  ctrlQ;
    logic [31:0] wdataQ;
    logic        rdQ;
    logic        wrQ;
    logic [31:0] rdataQ;
    logic        readyQ;
    logic        errQ;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] accAddr;
    logic [1:0]  accCtrl;
    logic [31:0] accWdata;
    logic        accRd;
    logic        accWr;
    logic [31:0] offset;
    logic [AW-1:0] wordIdx;
    logic [1:0]  lane;
    logic [31:0] memWord;
    logic [31:0] shifted;
    logic [31:0] wLanes;
    logic [3:0]  byteEn;
    logic        enterResp;
    logic        errD;
    logic [31:0] rdataD;

    // The access is evaluated from the live inputs when the response is
    // produced straight out of IDLE (zero wait states), otherwise from the
    // request latched at acceptance.
    always_comb begin
        accAddr  = (stateQ == S_IDLE) ? data_addr       : addrQ;
        accCtrl  = (stateQ == S_IDLE) ? data_rd_wr_ctrl : ctrlQ;
        accWdata = (stateQ == S_IDLE) ? data_wr         : wdataQ;
        accRd    = (stateQ == S_IDLE) ? data_rd_en      : rdQ;
        accWr    = (stateQ == S_IDLE) ? data_wr_en      : wrQ;

        // Subtraction wraps addresses below BASE_ADDR to huge offsets, so a
        // single unsigned compare covers both range limits.
        offset  = accAddr - BASE_ADDR;
        wordIdx = offset[AW+1:2];
        lane    = accAddr[1:0];

        errD = (accRd & accWr)
             | (accCtrl == 2'b11)
             | ((accCtrl == 2'b01) & accAddr[0])
             | ((accCtrl == 2'b10) & (accAddr[1:0] != 2'b00))
             | (offset >= MEM_BYTES);

        enterResp = clk_en & (((stateQ == S_IDLE) & (data_rd_en | data_wr_en) & (WAIT_STATES == 0))
                           | ((stateQ == S_WAIT) & (cntQ == 4'd1)));

        memWord = mem[wordIdx];
        shifted = memWord >> {lane, 3'b000};

        rdataD = 32'd0;
        if (accRd && !errD) begin
            case (accCtrl)
                2'b00:   rdataD = {24'd0, shifted[7:0]};
                2'b01:   rdataD = {16'd0, shifted[15:0]};
                default: rdataD = memWord;
            endcase
        end

        // Store data is replicated across lanes; byteEn picks the lanes.
        case (accCtrl)
            2'b00: begin
                byteEn = 4'b0001 << lane;
                wLanes = {4{accWdata[7:0]}};
            end
            2'b01: begin
                byteEn = 4'b0011 << lane;
                wLanes = {2{accWdata[15:0]}};
            end
            2'b10: begin
                byteEn = 4'b1111;
                wLanes = accWdata;
            end
            default: begin
                byteEn = 4'b0000;
                wLanes = accWdata;
            end
        endcase
    end

    // Memory array is not reset; rst_n gates the commit so a write whose
    // response edge coincides with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && enterResp && accWr && !errD) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[wordIdx][8*i +: 8] <= wLanes[8*i +: 8];
                end
            end
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= S_IDLE;
            cntQ   <= 4'd0;
            addrQ  <= 32'd0;
            ctrlQ  <= 2'b00;
            wdataQ <= 32'd0;
            rdQ    <= 1'b0;
            wrQ    <= 1'b0;
            rdataQ <= 32'd0;
            readyQ <= 1'b0;
            errQ   <= 1'b0;
        end else if (clk_en) begin
            case (stateQ)
                S_IDLE: begin
                    readyQ <= 1'b0;
                    errQ   <= 1'b0;
                    if (data_rd_en || data_wr_en) begin
                        addrQ  <= data_addr;
                        ctrlQ  <= data_rd_wr_ctrl;
                        wdataQ <= data_wr;
                        rdQ    <= data_rd_en;
                        wrQ    <= data_wr_en;
                        cntQ   <= WAIT_INIT;
                        if (enterResp) begin
                            stateQ <= S_RESP;
                            readyQ <= 1'b1;
                            errQ   <= errD;
                            rdataQ <= rdataD;
                        end else begin
                            stateQ <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    cntQ <= cntQ - 4'd1;
                    if (cntQ == 4'd1) begin
                        stateQ <= S_RESP;
                        readyQ <= 1'b1;
                        errQ   <= errD;
                        rdataQ <= rdataD;
                    end
                end
                S_RESP: begin
                    // Inputs ignored here so a held request is not re-accepted.
                    readyQ <= 1'b0;
                    errQ   <= 1'b0;
                    stateQ <= S_IDLE;
                end
                default: begin
                    stateQ <= S_IDLE;
                end
            endcase
        end
    end

    assign data_rd    = rdataQ;
    assign data_ready = readyQ;
    assign data_err   = errQ;

endmodule
